sram_phy_ctrl: RTL and testbench
================================

// Module: sram_phy_ctrl
// PURPOSE
//  Downstream stage of the AXI-to-SRAM front end: accepts one request at a time on the
//  sram_req/sram_ready handshake and sequences the Blackice-II 256Kx16 async SRAM pins.
//  Reads return data on sram_rd_data_vld exactly WAIT_CYCLES+2 cycles after acceptance.
//  Top level wraps pin_data_* in tristate IO cells; this block has no inout ports.
// PARAMETERS
//  ADDR_WIDTH   18  SRAM word address width
//  DATA_WIDTH   16  SRAM data width; byte enables = DATA_WIDTH/8
//  WAIT_CYCLES  2   access wait states, >=1. Default gives read latency 4, the front-end contract.
// PORTS
//  a_clk             in   1    single clock
//  a_rst             in   1    synchronous reset, active-high
//  sram_req          in   1    request valid; held until sram_ready
//  sram_ready        out  1    request accepted this cycle (req & ready)
//  sram_rd           in   1    1=read, 0=write
//  sram_addr         in   18   word address
//  sram_be           in   2    byte enables, bit1=upper; writes only
//  sram_wr_data      in   16   write data
//  sram_rd_data_vld  out  1    one-cycle strobe, read data valid
//  sram_rd_data      out  16   read data, registered, held until next capture
//  pin_ce_n          out  1    chip enable, active-low
//  pin_oe_n          out  1    output enable, active-low
//  pin_we_n          out  1    write enable, active-low
//  pin_ub_n/pin_lb_n out  1    upper/lower byte enable, active-low
//  pin_addr          out  18   address pins
//  pin_data_out      out  16   data driven when pin_data_oe=1
//  pin_data_oe       out  1    FPGA drives data bus
//  pin_data_in       in   16   data bus sampled value
// BEHAVIOUR
//  Reset: state IDLE; ce_n/oe_n/we_n/ub_n/lb_n=1; data_oe=0; pin_addr=0; ready=0; vld=0; rd_data=0.
//  sram_ready = (state==IDLE) & sram_req, combinational; never high without req.
//  Accept (cycle T): rd, addr, be, wr_data latched; later changes on inputs ignored.
//  FSM: IDLE -> RD_ACC (1+WAIT_CYCLES cycles) -> IDLE; IDLE -> WR_ACC (1+WAIT_CYCLES) -> WR_HOLD (1) -> IDLE.
//  Read: T+1..T+1+WAIT_CYCLES ce_n=0, oe_n=0, ub_n=lb_n=0, data_oe=0, addr stable.
//   pin_data_in registered at edge ending last wait cycle; vld=1 for one cycle at T+WAIT_CYCLES+2;
//   state is IDLE in that cycle, so next accept may coincide with vld.
//  Write: WR_ACC: ce_n=0, we_n=0, oe_n=1, ub_n/lb_n=~be, data_oe=1, addr/data stable.
//   WR_HOLD: we_n=1, ce_n=0, addr/data/data_oe held (hold time); then IDLE. No write response here.
//  be=2'b00 write: full cycle runs, both byte enables stay high, nothing written.
//  All pin outputs are registered; no glitches; oe_n and we_n never low together.
//  Reset mid-operation: next edge returns to IDLE with pins deasserted; pending read gives no vld.
//  Write after read: read drove oe_n=0; write data_oe asserted one cycle after oe_n release minimum.
// CONFIGURATION
//  SRAM_TURNAROUND_EN defined: after any read, one extra IDLE_TA cycle (ready=0, pins idle)
//   before next accept, guaranteeing bus turnaround; read latency unchanged.
//  Undefined: back-to-back accept at vld cycle; write after read relies on 1-cycle oe_n gap
//   inherent in accept cycle.
// STRUCTURE
//  Shared package file sram_defs.vh: state encodings, SRAM_RD/SRAM_WR opcode consts,
//   default timing consts, read latency expression WAIT_CYCLES+2 used by front end and formal props.
//  Sub-module sram_wait_ctr: loadable down-counter, load/zero flag, sequences wait states.
// TESTING
//  Read addr 18'h00123, pin_data_in=16'hBEEF -> pins ce_n=oe_n=0 T+1..T+3, vld=1 at T+4, data BEEF.
//  Write addr 18'h3FFFF data 16'hA55A be=2'b10 -> ub_n=0 lb_n=1 we_n=0 T+1..T+3, WR_HOLD T+4, ready at T+5.
//  Back-to-back reads with req held -> second accept at T+4 with first vld; vld at T+4 and T+8.
//  Read then write: with SRAM_TURNAROUND_EN next accept T+5, without T+4; data_oe never with oe_n=0.
//  a_rst asserted at T+2 of a read -> all pins idle next cycle, no vld, ready again after reset drops.
//  Write be=2'b00 -> ub_n=lb_n=1 throughout, cycle timing identical to normal write.

Source files
------------

// File: rtl/sram_phy_ctrl_pkg.sv
// Shared definitions for the async SRAM PHY controller: FSM states, opcodes, timing defaults.
package sram_phy_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdAcc,
        StWrAcc,
        StWrHold,
        StIdleTa
    } state_e;

    localparam logic SramRd = 1'b1;
    localparam logic SramWr = 1'b0;

    localparam int unsigned DefAddrWidth  = 18;
    localparam int unsigned DefDataWidth  = 16;
    localparam int unsigned DefWaitCycles = 2;

    // Cycles from request acceptance to the read-data strobe.
    function automatic int unsigned read_latency(input int unsigned wait_cycles);
        return wait_cycles + 2;
    endfunction

endpackage

// File: rtl/sram_phy_ctrl_wait_ctr.sv
// Loadable down-counter that times the SRAM access wait states; o_zero marks the last cycle.
module sram_phy_ctrl_wait_ctr #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_phy_ctrl.sv
// Single-request sequencer for a 256Kx16 async SRAM; all pin outputs are registered.
// Optional macro SRAM_TURNAROUND_EN inserts one idle turnaround cycle after every read.
module sram_phy_ctrl
    import sram_phy_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
    input  logic                    a_clk,
    input  logic                    a_rst,
    input  logic                    sram_req,
    output logic                    sram_ready,
    input  logic                    sram_rd,
    input  logic [ADDR_WIDTH-1:0]   sram_addr,
    input  logic [DATA_WIDTH/8-1:0] sram_be,
    input  logic [DATA_WIDTH-1:0]   sram_wr_data,
    output logic                    sram_rd_data_vld,
    output logic [DATA_WIDTH-1:0]   sram_rd_data,
    output logic                    pin_ce_n,
    output logic                    pin_oe_n,
    output logic                    pin_we_n,
    output logic                    pin_ub_n,
    output logic                    pin_lb_n,
    output logic [ADDR_WIDTH-1:0]   pin_addr,
    output logic [DATA_WIDTH-1:0]   pin_data_out,
    output logic                    pin_data_oe,
    input  logic [DATA_WIDTH-1:0]   pin_data_in
);

    localparam int unsigned BeW  = DATA_WIDTH / 8;
    localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);

    state_e                r_state, w_state_d;
    logic                  w_accept, w_cnt_zero, w_cnt_dec, w_capture;
    logic [BeW-1:0]        r_be, w_be;
    logic                  r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n, r_data_oe;
    logic                  w_ce_n_d, w_oe_n_d, w_we_n_d, w_ub_n_d, w_lb_n_d, w_data_oe_d;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data_out, r_rd_data;
    logic                  r_vld;

    assign w_accept   = (r_state == StIdle) && sram_req && !a_rst;
    assign sram_ready = w_accept;
    assign w_cnt_dec  = (r_state == StRdAcc) || (r_state == StWrAcc);
    assign w_capture  = (r_state == StRdAcc) && w_cnt_zero;
    // Byte enables seen by the pins: live inputs on the accept edge, latched copy afterwards.
    assign w_be       = w_accept ? sram_be : r_be;

    sram_phy_ctrl_wait_ctr #(
        .WIDTH (CntW)
    ) u_wait_ctr (
        .i_clk      (a_clk),
        .i_rst      (a_rst),
        .i_load     (w_accept),
        .i_load_val (CntW'(WAIT_CYCLES)),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:   if (w_accept) w_state_d = (sram_rd == SramRd) ? StRdAcc : StWrAcc;
            StRdAcc: begin
                if (w_cnt_zero) begin
`ifdef SRAM_TURNAROUND_EN
                    w_state_d = StIdleTa;
`else
                    w_state_d = StIdle;
`endif
                end
            end
            StWrAcc:  if (w_cnt_zero) w_state_d = StWrHold;
            StWrHold: w_state_d = StIdle;
            StIdleTa: w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Pin levels are a function of the state being entered, so they change only on clock edges.
    always_comb begin
        w_ce_n_d    = 1'b1;
        w_oe_n_d    = 1'b1;
        w_we_n_d    = 1'b1;
        w_ub_n_d    = 1'b1;
        w_lb_n_d    = 1'b1;
        w_data_oe_d = 1'b0;
        case (w_state_d)
            StRdAcc: begin
                w_ce_n_d = 1'b0;
                w_oe_n_d = 1'b0;
                w_ub_n_d = 1'b0;
                w_lb_n_d = 1'b0;
            end
            StWrAcc, StWrHold: begin
                w_ce_n_d    = 1'b0;
                w_we_n_d    = (w_state_d == StWrHold);
                w_ub_n_d    = ~w_be[BeW-1];
                w_lb_n_d    = ~w_be[0];
                w_data_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            r_state    <= StIdle;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_ub_n     <= 1'b1;
            r_lb_n     <= 1'b1;
            r_data_oe  <= 1'b0;
            r_addr     <= '0;
            r_data_out <= '0;
            r_be       <= '0;
            r_vld      <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_state   <= w_state_d;
            r_ce_n    <= w_ce_n_d;
            r_oe_n    <= w_oe_n_d;
            r_we_n    <= w_we_n_d;
            r_ub_n    <= w_ub_n_d;
            r_lb_n    <= w_lb_n_d;
            r_data_oe <= w_data_oe_d;
            r_vld     <= w_capture;
            if (w_accept) begin
                r_addr     <= sram_addr;
                r_data_out <= sram_wr_data;
                r_be       <= sram_be;
            end
            if (w_capture) r_rd_data <= pin_data_in;
        end
    end

    assign pin_ce_n         = r_ce_n;
    assign pin_oe_n         = r_oe_n;
    assign pin_we_n         = r_we_n;
    assign pin_ub_n         = r_ub_n;
    assign pin_lb_n         = r_lb_n;
    assign pin_data_oe      = r_data_oe;
    assign pin_addr         = r_addr;
    assign pin_data_out     = r_data_out;
    assign sram_rd_data_vld = r_vld;
    assign sram_rd_data     = r_rd_data;

endmodule

// File: tb/tb_sram_phy_ctrl.sv
// Directed bench for sram_phy_ctrl with a read-data scoreboard; honours SRAM_TURNAROUND_EN.
module tb_sram_phy_ctrl;

    localparam int unsigned WC  = 2;
    localparam int unsigned Lat = WC + 2;
`ifdef SRAM_TURNAROUND_EN
    localparam int unsigned Ta = 1;
`else
    localparam int unsigned Ta = 0;
`endif
    // Pin vector order: {ce_n, oe_n, we_n, ub_n, lb_n, data_oe}
    localparam logic [5:0] PIdle = 6'b111110;
    localparam logic [5:0] PRd   = 6'b001000;

    logic        a_clk = 1'b0;
    logic        a_rst;
    logic        sram_req, sram_rd;
    logic [17:0] sram_addr;
    logic [1:0]  sram_be;
    logic [15:0] sram_wr_data, pin_data_in;
    logic        sram_ready, sram_rd_data_vld;
    logic [15:0] sram_rd_data, pin_data_out;
    logic        pin_ce_n, pin_oe_n, pin_we_n, pin_ub_n, pin_lb_n, pin_data_oe;
    logic [17:0] pin_addr;
    logic [5:0]  w_pins;

    sram_phy_ctrl #(
        .ADDR_WIDTH  (18),
        .DATA_WIDTH  (16),
        .WAIT_CYCLES (WC)
    ) dut (
        .a_clk            (a_clk),
        .a_rst            (a_rst),
        .sram_req         (sram_req),
        .sram_ready       (sram_ready),
        .sram_rd          (sram_rd),
        .sram_addr        (sram_addr),
        .sram_be          (sram_be),
        .sram_wr_data     (sram_wr_data),
        .sram_rd_data_vld (sram_rd_data_vld),
        .sram_rd_data     (sram_rd_data),
        .pin_ce_n         (pin_ce_n),
        .pin_oe_n         (pin_oe_n),
        .pin_we_n         (pin_we_n),
        .pin_ub_n         (pin_ub_n),
        .pin_lb_n         (pin_lb_n),
        .pin_addr         (pin_addr),
        .pin_data_out     (pin_data_out),
        .pin_data_oe      (pin_data_oe),
        .pin_data_in      (pin_data_in)
    );

    assign w_pins = {pin_ce_n, pin_oe_n, pin_we_n, pin_ub_n, pin_lb_n, pin_data_oe};

    always #5 a_clk = ~a_clk;

    int cyc = 0;
    always @(posedge a_clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    logic [15:0] q_data[$];
    int          q_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge a_clk);
    endtask

    // Bus invariants every cycle, plus scoreboard pop on each read strobe.
    always @(negedge a_clk) begin
        logic [15:0] d;
        int          c;
        if (mon_en) begin
            check("oe_we_exclusive", {31'd0, pin_oe_n | pin_we_n}, 1);
            check("data_oe_vs_oe", {31'd0, pin_oe_n | !pin_data_oe}, 1);
            if (sram_rd_data_vld) begin
                if (q_data.size() == 0) begin
                    check("vld_unexpected", {31'd0, sram_rd_data_vld}, 0);
                end else begin
                    d = q_data.pop_front();
                    c = q_cyc.pop_front();
                    check("rd_data", {16'd0, sram_rd_data}, {16'd0, d});
                    check("rd_latency_cyc", cyc, c);
                end
            end
        end
    end

    task automatic do_read(input logic [17:0] a, input logic [15:0] d);
        int t;
        sram_req = 1'b1; sram_rd = 1'b1; sram_addr = a; pin_data_in = d;
        sample();
        check("rd_ready", {31'd0, sram_ready}, 1);
        t = cyc;
        q_data.push_back(d);
        q_cyc.push_back(t + Lat);
        tick();
        sram_req = 1'b0; sram_addr = ~a;
        for (int i = 1; i <= WC + 1; i++) begin
            sample();
            check("rd_pins", {26'd0, w_pins}, {26'd0, PRd});
            check("rd_addr", {14'd0, pin_addr}, {14'd0, a});
            tick();
        end
        sample();
        check("rd_pins_done", {26'd0, w_pins}, {26'd0, PIdle});
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic [1:0] b);
        logic [5:0] p_acc, p_hold;
        p_acc  = {1'b0, 1'b1, 1'b0, ~b[1], ~b[0], 1'b1};
        p_hold = {1'b0, 1'b1, 1'b1, ~b[1], ~b[0], 1'b1};
        sram_req = 1'b1; sram_rd = 1'b0; sram_addr = a; sram_wr_data = d; sram_be = b;
        sample();
        check("wr_ready", {31'd0, sram_ready}, 1);
        tick();
        sram_req = 1'b0; sram_wr_data = ~d; sram_be = ~b; sram_addr = ~a;
        for (int i = 1; i <= WC + 1; i++) begin
            sample();
            check("wr_pins", {26'd0, w_pins}, {26'd0, p_acc});
            check("wr_addr", {14'd0, pin_addr}, {14'd0, a});
            check("wr_data", {16'd0, pin_data_out}, {16'd0, d});
            tick();
        end
        sram_req = 1'b1; sram_rd = 1'b1;
        sample();
        check("wr_hold_pins", {26'd0, w_pins}, {26'd0, p_hold});
        check("wr_hold_data", {16'd0, pin_data_out}, {16'd0, d});
        check("wr_hold_ready", {31'd0, sram_ready}, 0);
        tick();
        sample();
        check("wr_done_pins", {26'd0, w_pins}, {26'd0, PIdle});
        check("wr_done_ready", {31'd0, sram_ready}, 1);
        sram_req = 1'b0;
    endtask

    initial begin
        int t, t2;
        a_rst = 1'b1; sram_req = 1'b0; sram_rd = 1'b0; sram_addr = '0;
        sram_be = '0; sram_wr_data = '0; pin_data_in = '0;
        tick(); tick();
        sample();
        check("rst_pins", {26'd0, w_pins}, {26'd0, PIdle});
        check("rst_ready", {31'd0, sram_ready}, 0);
        check("rst_vld", {31'd0, sram_rd_data_vld}, 0);
        check("rst_rd_data", {16'd0, sram_rd_data}, 0);
        check("rst_addr", {14'd0, pin_addr}, 0);
        mon_en = 1'b1;
        tick();
        a_rst = 1'b0;
        tick();

        do_read(18'h00123, 16'hBEEF);
        tick();
        do_write(18'h3FFFF, 16'hA55A, 2'b10);
        tick();
        do_write(18'h00005, 16'h1234, 2'b00);
        tick();

        // Back-to-back reads with the request held.
        sram_req = 1'b1; sram_rd = 1'b1; sram_addr = 18'h00010; pin_data_in = 16'h1111;
        sample();
        check("b2b_ready1", {31'd0, sram_ready}, 1);
        t = cyc;
        q_data.push_back(16'h1111);
        q_cyc.push_back(t + Lat);
        tick();
        sram_addr = 18'h00020;
        for (int i = 1; i < Lat + Ta; i++) begin
            if (i == Lat) pin_data_in = 16'h2222;
            sample();
            check("b2b_busy", {31'd0, sram_ready}, 0);
            tick();
        end
        pin_data_in = 16'h2222;
        sample();
        check("b2b_ready2", {31'd0, sram_ready}, 1);
        t2 = cyc;
        check("b2b_accept_cyc", t2, t + Lat + Ta);
        q_data.push_back(16'h2222);
        q_cyc.push_back(t2 + Lat);
        tick();
        sram_req = 1'b0;
        repeat (Lat + 2) tick();

        // Read followed by a held write request.
        sram_req = 1'b1; sram_rd = 1'b1; sram_addr = 18'h00055; pin_data_in = 16'h3C3C;
        sample();
        check("rw_ready_rd", {31'd0, sram_ready}, 1);
        t = cyc;
        q_data.push_back(16'h3C3C);
        q_cyc.push_back(t + Lat);
        tick();
        sram_rd = 1'b0; sram_addr = 18'h00066; sram_wr_data = 16'h9999; sram_be = 2'b11;
        for (int i = 1; i < Lat + Ta; i++) begin
            sample();
            check("rw_busy", {31'd0, sram_ready}, 0);
            tick();
        end
        sample();
        check("rw_ready_wr", {31'd0, sram_ready}, 1);
        check("rw_accept_cyc", cyc, t + Lat + Ta);
        tick();
        sram_req = 1'b0;
        sample();
        check("rw_wr_pins", {26'd0, w_pins}, {26'd0, 6'b010001});
        repeat (Lat + 2) tick();

        // Reset in the middle of a read: no strobe may follow.
        sram_req = 1'b1; sram_rd = 1'b1; sram_addr = 18'h00077; pin_data_in = 16'hDEAD;
        sample();
        check("rr_ready", {31'd0, sram_ready}, 1);
        tick();
        sram_req = 1'b0;
        tick();
        a_rst = 1'b1;
        sample();
        check("rr_pins_before", {26'd0, w_pins}, {26'd0, PRd});
        tick();
        sram_req = 1'b1;
        sample();
        check("rr_pins_after", {26'd0, w_pins}, {26'd0, PIdle});
        check("rr_ready_in_rst", {31'd0, sram_ready}, 0);
        check("rr_vld", {31'd0, sram_rd_data_vld}, 0);
        tick();
        a_rst = 1'b0;
        pin_data_in = 16'h5AA5;
        sample();
        check("rr_ready_after", {31'd0, sram_ready}, 1);
        q_data.push_back(16'h5AA5);
        q_cyc.push_back(cyc + Lat);
        tick();
        sram_req = 1'b0;
        repeat (Lat + 3) tick();

        check("queue_drained", q_data.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
